// File: rtl/vram_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vram_writer: host write FIFO plus block-fill engine driving an async SRAM    |
// | through an IDLE/SETUP/WRITE/HOLD strobe sequence.            Revision: 1.0   |
// +-----------------------------------------------------------------------------+
module vram_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WE_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [17:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_mask,
  input  logic        fill_start,
  input  logic [17:0] fill_addr,
  input  logic [11:0] fill_len,
  input  logic [15:0] fill_data,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [17:0] ram_addr,
  output logic [15:0] ram_dout,
  output logic        ram_drive,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we,
  output logic        ram_lb,
  output logic        ram_hb
);

  localparam int             c_AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_AW:0]  c_FULL    = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]     c_WE_LAST = 3'(WE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // FIFO entry layout: {mask[1:0], addr[17:0], data[15:0]}
  logic [35:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  state_t          r_state;
  logic [2:0]      r_we_cnt;
  logic            r_src_fill;
  logic [17:0]     r_fill_addr;
  logic [11:0]     r_fill_rem;
  logic [15:0]     r_fill_data;

  logic            w_push;
  logic            w_pop;
  logic            w_hold_done;
  logic            w_fill_last;
  logic            w_fill_accept;
  logic            w_fill_busy_next;
  logic [c_AW:0]   w_count_next;
  logic            w_pending;
  logic            w_pending_next;
  logic [35:0]     w_head;

  assign wr_ready         = (r_count != c_FULL) && !fill_busy;
  assign w_push           = wr_valid && wr_ready;
  assign w_hold_done      = (r_state == HOLD);
  assign w_pop            = w_hold_done && !r_src_fill;
  assign w_fill_last      = w_hold_done && r_src_fill && (r_fill_rem == 12'd1);
  // A simultaneous push makes the FIFO non-empty, so it takes precedence over a fill.
  assign w_fill_accept    = fill_start && !fill_busy && (r_count == '0) &&
                            (r_state == IDLE) && (fill_len != 12'd0) && !w_push;
  assign w_fill_busy_next = w_fill_accept || (fill_busy && !w_fill_last);
  assign w_count_next     = r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
  assign w_pending        = (r_count != '0) || fill_busy;
  assign w_pending_next   = (w_count_next != '0) || w_fill_busy_next;
  assign w_head           = r_mem[r_rd_ptr];
  assign ram_oe           = 1'b0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {wr_mask, wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_busy   <= 1'b0;
      fill_done   <= 1'b0;
      r_fill_addr <= '0;
      r_fill_rem  <= '0;
      r_fill_data <= '0;
    end else begin
      fill_done <= w_fill_last;
      if (w_fill_accept) begin
        fill_busy   <= 1'b1;
        r_fill_addr <= fill_addr;
        r_fill_rem  <= fill_len;
        r_fill_data <= fill_data;
      end else if (w_hold_done && r_src_fill) begin
        r_fill_addr <= r_fill_addr + 18'd1;
        r_fill_rem  <= r_fill_rem - 12'd1;
        if (w_fill_last) fill_busy <= 1'b0;
      end
    end
  end

  // bus_req is computed from next-cycle state so it rises with the push or fill accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_we_cnt   <= '0;
      r_src_fill <= 1'b0;
      bus_req    <= 1'b0;
      ram_ce     <= 1'b0;
      ram_we     <= 1'b0;
      ram_drive  <= 1'b0;
      ram_lb     <= 1'b0;
      ram_hb     <= 1'b0;
      ram_addr   <= '0;
      ram_dout   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          ram_ce    <= 1'b0;
          ram_we    <= 1'b0;
          ram_drive <= 1'b0;
          if (w_pending && bus_grant) begin
            r_state    <= SETUP;
            r_src_fill <= fill_busy;
            bus_req    <= 1'b1;
            ram_ce     <= 1'b1;
            ram_drive  <= 1'b1;
            if (fill_busy) begin
              ram_addr <= r_fill_addr;
              ram_dout <= r_fill_data;
              ram_lb   <= 1'b1;
              ram_hb   <= 1'b1;
            end else begin
              ram_addr <= w_head[33:16];
              ram_dout <= w_head[15:0];
              ram_lb   <= w_head[34];
              ram_hb   <= w_head[35];
            end
          end else begin
            bus_req <= w_pending_next;
          end
        end
        SETUP: begin
          r_state  <= WRITE;
          r_we_cnt <= '0;
          ram_we   <= 1'b1;
          bus_req  <= 1'b1;
        end
        WRITE: begin
          bus_req <= 1'b1;
          if (r_we_cnt == c_WE_LAST) begin
            r_state <= HOLD;
            ram_we  <= 1'b0;
          end else begin
            r_we_cnt <= r_we_cnt + 3'd1;
          end
        end
        HOLD: begin
          r_state   <= IDLE;
          ram_ce    <= 1'b0;
          ram_drive <= 1'b0;
          bus_req   <= w_pending_next;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_vram_writer: directed bench for vram_writer.              Revision: 1.0   |
// +-----------------------------------------------------------------------------+
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        fill_start = 1'b0;
  logic [17:0] fill_addr = '0;
  logic [11:0] fill_len = '0;
  logic [15:0] fill_data = '0;
  logic        fill_busy, fill_done, bus_req;
  logic        bus_grant = 1'b0;
  logic [17:0] ram_addr;
  logic [15:0] ram_dout;
  logic        ram_drive, ram_ce, ram_oe, ram_we, ram_lb, ram_hb;

  int errors = 0;
  int checks = 0;

  vram_writer #(.FIFO_DEPTH(4), .WE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len),
    .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_drive(ram_drive),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_lb(ram_lb), .ram_hb(ram_hb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [17:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_we(input string tag);
    int n;
    n = 0;
    while (ram_we !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(ram_we), 32'd1);
  endtask

  logic [17:0] waddr [8];
  logic [15:0] wdata [8];
  int          wcyc  [8];
  int          nw, ndone, nce;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ce", 32'(ram_ce), 0);
    check("rst_we", 32'(ram_we), 0);
    check("rst_drive", 32'(ram_drive), 0);
    check("rst_bus_req", 32'(bus_req), 0);
    check("rst_fill_busy", 32'(fill_busy), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_dout", 32'(ram_dout), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    reset = 1'b0;
    tick();

    // Single write: SETUP one edge after the push, WE two edges after.
    bus_grant = 1'b1;
    push(18'h02040, 16'hA5C3, 2'b11);
    check("w1_bus_req_push", 32'(bus_req), 1);
    check("w1_idle_ce", 32'(ram_ce), 0);
    tick();
    check("w1_setup_ce", 32'(ram_ce), 1);
    check("w1_setup_we", 32'(ram_we), 0);
    check("w1_setup_drive", 32'(ram_drive), 1);
    check("w1_setup_oe", 32'(ram_oe), 0);
    check("w1_setup_addr", 32'(ram_addr), 32'h02040);
    tick();
    check("w1_write_we", 32'(ram_we), 1);
    check("w1_write_addr", 32'(ram_addr), 32'h02040);
    check("w1_write_dout", 32'(ram_dout), 32'hA5C3);
    check("w1_write_lbhb", 32'({ram_hb, ram_lb}), 32'h3);
    tick();
    check("w1_hold_we", 32'(ram_we), 0);
    check("w1_hold_ce", 32'(ram_ce), 1);
    check("w1_hold_bus_req", 32'(bus_req), 1);
    tick();
    check("w1_idle_ce_after", 32'(ram_ce), 0);
    check("w1_bus_req_fall", 32'(bus_req), 0);

    // Grant withheld: fill the FIFO, then one extra push that must be dropped.
    bus_grant = 1'b0;
    for (int i = 0; i < 4; i++) push(18'h00100 + 18'(i), 16'h1000 + 16'(i), 2'b11);
    check("gw_ready_full", 32'(wr_ready), 0);
    check("gw_no_ce", 32'(ram_ce), 0);
    check("gw_bus_req", 32'(bus_req), 1);
    push(18'h3DEAD, 16'hDEAD, 2'b11);
    bus_grant = 1'b1;
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (ram_we === 1'b1) begin
        if (nw < 8) begin
          waddr[nw] = ram_addr; wdata[nw] = ram_dout; wcyc[nw] = c;
        end
        nw++;
      end
      tick();
    end
    check("gw_count", 32'(nw), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("gw_addr%0d", i), 32'(waddr[i]), 32'h100 + 32'(i));
      check($sformatf("gw_data%0d", i), 32'(wdata[i]), 32'h1000 + 32'(i));
    end
    for (int i = 1; i < 4; i++)
      check($sformatf("gw_spacing%0d", i), 32'(wcyc[i] - wcyc[i-1]), 4);
    check("gw_ready_drained", 32'(wr_ready), 1);

    // Byte mask low byte only.
    push(18'h00010, 16'h00FF, 2'b01);
    wait_we("mask_wait_we");
    check("mask_lb", 32'(ram_lb), 1);
    check("mask_hb", 32'(ram_hb), 0);
    repeat (3) tick();

    // Fill across the top of the address space.
    fill_start = 1'b1; fill_addr = 18'h3FFFE; fill_len = 12'd3; fill_data = 16'h0000;
    tick();
    fill_start = 1'b0;
    check("fill_busy_set", 32'(fill_busy), 1);
    check("fill_wr_ready", 32'(wr_ready), 0);
    nw = 0; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (ram_we === 1'b1) begin
        if (nw < 8) begin
          waddr[nw] = ram_addr; wdata[nw] = {14'd0, ram_hb, ram_lb};
        end
        nw++;
      end
      if (fill_done === 1'b1) begin
        ndone++;
        check("fill_busy_at_done", 32'(fill_busy), 0);
      end
      tick();
    end
    check("fill_count", 32'(nw), 3);
    check("fill_addr0", 32'(waddr[0]), 32'h3FFFE);
    check("fill_addr1", 32'(waddr[1]), 32'h3FFFF);
    check("fill_addr2", 32'(waddr[2]), 32'h00000);
    check("fill_lbhb", 32'(wdata[2]), 32'h3);
    check("fill_done_pulses", 32'(ndone), 1);
    check("fill_busy_end", 32'(fill_busy), 0);

    // Push and fill_start together: push wins; zero-length fill is ignored.
    wr_valid = 1'b1; wr_addr = 18'h00077; wr_data = 16'h7777; wr_mask = 2'b11;
    fill_start = 1'b1; fill_addr = 18'h0; fill_len = 12'd5;
    tick();
    wr_valid = 1'b0; fill_start = 1'b0;
    check("pf_fill_ignored", 32'(fill_busy), 0);
    wait_we("pf_wait_we");
    check("pf_addr", 32'(ram_addr), 32'h00077);
    repeat (3) tick();
    fill_start = 1'b1; fill_len = 12'd0;
    tick();
    fill_start = 1'b0;
    check("len0_ignored", 32'(fill_busy), 0);
    check("len0_bus_req", 32'(bus_req), 0);

    // Grant dropped during WRITE: the cycle still finishes.
    push(18'h00ABC, 16'hBEEF, 2'b11);
    wait_we("gd_wait_we");
    bus_grant = 1'b0;
    check("gd_addr", 32'(ram_addr), 32'h00ABC);
    tick();
    check("gd_hold_ce", 32'(ram_ce), 1);
    check("gd_hold_we", 32'(ram_we), 0);
    tick();
    check("gd_idle_ce", 32'(ram_ce), 0);
    check("gd_bus_req", 32'(bus_req), 0);

    // Reset during WRITE with another entry queued.
    push(18'h000A1, 16'h00A1, 2'b11);
    push(18'h000A2, 16'h00A2, 2'b11);
    bus_grant = 1'b1;
    wait_we("rs_wait_we");
    reset = 1'b1;
    #1;
    check("rs_we_async", 32'(ram_we), 0);
    check("rs_drive_async", 32'(ram_drive), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rs_wr_ready", 32'(wr_ready), 1);
    check("rs_bus_req", 32'(bus_req), 0);
    nce = 0;
    for (int c = 0; c < 10; c++) begin
      if (ram_ce === 1'b1) nce++;
      tick();
    end
    check("rs_fifo_empty", 32'(nce), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, host write-request FIFO entries (power of two, at least 2).
REQ-002 Parameter WE_CYCLES, default 1, number of clk cycles ram_we is held high per write (1-4).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset; asynchronous, active-high.
REQ-005 wr_valid  input  1  host write request present.
REQ-006 wr_ready  output  1  FIFO can accept; a push occurs on a clk edge where wr_valid and wr_ready are both 1.
REQ-007 wr_addr  input  18  VRAM word address.
REQ-008 wr_data  input  16  VRAM word data.
REQ-009 wr_mask  input  2  byte enables: [0] drives ram_lb, [1] drives ram_hb.
REQ-010 fill_start  input  1  single-cycle pulse starting a block fill.
REQ-011 fill_addr  input  18  first fill address.
REQ-012 fill_len  input  12  number of words to fill.
REQ-013 fill_data  input  16  fill word; both bytes are always written.
REQ-014 fill_busy  output  1  fill in progress.
REQ-015 fill_done  output  1  one-cycle pulse after the last fill word completes HOLD.
REQ-016 bus_req  output  1  writer wants or holds the SRAM bus.
REQ-017 bus_grant  input  1  arbiter (background fetcher side) releases the bus to the writer.
REQ-018 ram_addr  output  18  SRAM address.
REQ-019 ram_dout  output  16  SRAM write data.
REQ-020 ram_drive  output  1  data-bus output enable for ram_dout.
REQ-021 ram_ce, ram_oe, ram_we, ram_lb, ram_hb  output  1 each  SRAM strobes, active-high.

Function
REQ-022 Work is pending when the FIFO is non-empty or a fill has words remaining; bus_req equals work-pending OR FSM not in IDLE, and is registered.
REQ-023 The FSM has states IDLE, SETUP, WRITE, HOLD.
REQ-024 IDLE: ram_ce=0, ram_we=0, ram_drive=0; move to SETUP when work is pending and bus_grant=1; stay otherwise.
REQ-025 SETUP, 1 cycle: ram_addr, ram_dout, ram_lb and ram_hb are loaded from the selected source; ram_ce=1, ram_drive=1, ram_we=0.
REQ-026 WRITE, WE_CYCLES cycles: ram_we=1; address, data and byte enables are held.
REQ-027 HOLD, 1 cycle: ram_we=0, ram_ce=1, ram_drive=1; address and data are held; then go to IDLE.
REQ-028 The next write begins no earlier than IDLE-to-SETUP, so each write occupies at least WE_CYCLES+3 cycles.
REQ-029 ram_oe=0 whenever ram_ce=1; ram_we is never 1 outside WRITE.
REQ-030 bus_grant is sampled only in IDLE; deassertion in SETUP, WRITE or HOLD does not abort the cycle (the arbiter holds the fetcher off while bus_req=1).
REQ-031 Source priority: while fill_busy=1 the fill is the source; otherwise the FIFO head is the source.
REQ-032 The FIFO entry is popped on the HOLD-to-IDLE transition.
REQ-033 wr_ready = FIFO not full AND fill_busy=0.
REQ-034 A push and a pop in the same cycle leave the occupancy unchanged.
REQ-035 A push while the FIFO is full is ignored; no entry is overwritten.
REQ-036 fill_start is accepted only when fill_busy=0, the FIFO is empty, the FSM is in IDLE and fill_len≠0; otherwise it is ignored with no state change.
REQ-037 An accepted fill_start sets fill_busy=1 on the next edge and latches fill_addr, fill_len and fill_data.
REQ-038 Fill address increments by 1 per completed write, modulo 2^18 (0x3FFFF wraps to 0x00000).
REQ-039 The remaining-word counter decrements on each HOLD-to-IDLE transition.
REQ-040 When the remaining-word counter reaches 0, fill_busy falls and fill_done pulses on the same edge.
REQ-041 fill_start and a wr push in the same cycle: the push wins, because the FIFO becomes non-empty, and the fill is ignored.
REQ-042 Latency: with bus_grant held at 1 and the FSM idle, ram_we first rises 2 edges after the push edge.

Reset
REQ-043 Reset forces: FIFO empty, FSM IDLE, fill_busy=0, fill_done=0, bus_req=0, ram_ce=0, ram_oe=0, ram_we=0, ram_drive=0, ram_lb=0, ram_hb=0, ram_addr=0, ram_dout=0.
REQ-044 Reset asserted mid-write drops ram_we and ram_drive immediately (asynchronously); the in-flight entry is discarded.
REQ-045 After reset, wr_ready=1.

Verification
REQ-046 Single write: wr_addr=0x02040, wr_data=0xA5C3, wr_mask=2'b11, grant=1 -> ram_we high for exactly 1 cycle with ram_addr=0x02040, ram_dout=0xA5C3, lb=hb=1; bus_req falls after HOLD.
REQ-047 Grant withheld: push 4 entries with grant=0 -> wr_ready=0 after the 4th push and no ram_ce; then raise grant -> 4 writes in push order, each 4 cycles apart.
REQ-048 Byte mask: wr_mask=2'b01 -> during WRITE, ram_lb=1 and ram_hb=0.
REQ-049 Fill wrap: fill_addr=0x3FFFE, fill_len=3, fill_data=0x0000 -> writes to 0x3FFFE, 0x3FFFF, 0x00000, then one fill_done pulse, then fill_busy=0.
REQ-050 Grant drop and reset: drop grant during WRITE -> the write completes normally; assert reset during WRITE -> ram_we=0 and ram_drive=0 in the same cycle, FIFO empty afterwards.
